// File: rtl/min_max_tracker.sv
// Streaming frame statistics: running max/min with first-occurrence indices,
// sample count and forced-termination flag, presented on a held output handshake.
module min_max_tracker #(
    parameter int unsigned INPUT_BIT_WIDTH = 32,
    parameter int unsigned INDEX_BIT_WIDTH = 8,
    parameter bit          SIGNED          = 1'b0
) (
    input  logic                       Clk,
    input  logic                       Reset,
    input  logic                       Clear,
    input  logic                       InputValid,
    output logic                       InputReady,
    input  logic [INPUT_BIT_WIDTH-1:0] InputData,
    input  logic                       InputLast,
    output logic                       OutputValid,
    input  logic                       OutputReady,
    output logic [INPUT_BIT_WIDTH-1:0] Max,
    output logic [INPUT_BIT_WIDTH-1:0] Min,
    output logic [INDEX_BIT_WIDTH-1:0] MaxIndex,
    output logic [INDEX_BIT_WIDTH-1:0] MinIndex,
    output logic [INDEX_BIT_WIDTH:0]   Count,
    output logic                       Overflow
);

    typedef enum logic [1:0] {
        EMPTY,
        ACCUM,
        DONE
    } state_t;

    state_t                     state_q, state_d;
    logic [INPUT_BIT_WIDTH-1:0] max_q, max_d;
    logic [INPUT_BIT_WIDTH-1:0] min_q, min_d;
    logic [INDEX_BIT_WIDTH-1:0] max_idx_q, max_idx_d;
    logic [INDEX_BIT_WIDTH-1:0] min_idx_q, min_idx_d;
    logic [INDEX_BIT_WIDTH:0]   count_q, count_d;
    logic                       ovf_q, ovf_d;

    logic accept;
    logic out_accept;
    logic greater;
    logic less;
    logic last_slot;

    assign InputReady  = (state_q != DONE);
    assign OutputValid = (state_q == DONE);
    assign accept      = InputValid && InputReady;
    assign out_accept  = OutputValid && OutputReady;

    assign greater = SIGNED ? ($signed(InputData) > $signed(max_q)) : (InputData > max_q);
    assign less    = SIGNED ? ($signed(InputData) < $signed(min_q)) : (InputData < min_q);

    // The sample being accepted in ACCUM has index count_q; the last legal index is all-ones.
    assign last_slot = (count_q == {1'b0, {INDEX_BIT_WIDTH{1'b1}}});

    always_comb begin
        state_d   = state_q;
        max_d     = max_q;
        min_d     = min_q;
        max_idx_d = max_idx_q;
        min_idx_d = min_idx_q;
        count_d   = count_q;
        ovf_d     = ovf_q;

        if (Clear) begin
            state_d = EMPTY;
        end else begin
            unique case (state_q)
                EMPTY: begin
                    if (accept) begin
                        max_d     = InputData;
                        min_d     = InputData;
                        max_idx_d = '0;
                        min_idx_d = '0;
                        count_d   = {{INDEX_BIT_WIDTH{1'b0}}, 1'b1};
                        ovf_d     = 1'b0;
                        state_d   = InputLast ? DONE : ACCUM;
                    end
                end
                ACCUM: begin
                    if (accept) begin
                        if (greater) begin
                            max_d     = InputData;
                            max_idx_d = count_q[INDEX_BIT_WIDTH-1:0];
                        end
                        if (less) begin
                            min_d     = InputData;
                            min_idx_d = count_q[INDEX_BIT_WIDTH-1:0];
                        end
                        count_d = count_q + 1'b1;
                        if (InputLast) begin
                            state_d = DONE;
                        end else if (last_slot) begin
                            state_d = DONE;
                            ovf_d   = 1'b1;
                        end
                    end
                end
                DONE: begin
                    if (out_accept) begin
                        state_d = EMPTY;
                    end
                end
                default: state_d = EMPTY;
            endcase
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q   <= EMPTY;
            max_q     <= '0;
            min_q     <= '0;
            max_idx_q <= '0;
            min_idx_q <= '0;
            count_q   <= '0;
            ovf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            max_q     <= max_d;
            min_q     <= min_d;
            max_idx_q <= max_idx_d;
            min_idx_q <= min_idx_d;
            count_q   <= count_d;
            ovf_q     <= ovf_d;
        end
    end

    assign Max      = max_q;
    assign Min      = min_q;
    assign MaxIndex = max_idx_q;
    assign MinIndex = min_idx_q;
    assign Count    = count_q;
    assign Overflow = ovf_q;

endmodule

// File: tb/tb_min_max_tracker.sv
// Directed bench for min_max_tracker: default, signed 8-bit and short-index
// instances share stimulus; each test checks only the instance it targets.
module tb_min_max_tracker;

    logic        Clk = 1'b0;
    logic        Reset = 1'b0;
    logic        Clear = 1'b0;
    logic        InputValid = 1'b0;
    logic [31:0] InputData = '0;
    logic        InputLast = 1'b0;
    logic        OutputReady = 1'b0;

    always #5 Clk = ~Clk;

    // Instance 0: 32-bit unsigned, 8-bit index
    logic        ir0, ov0, of0;
    logic [31:0] max0, min0;
    logic [7:0]  maxi0, mini0;
    logic [8:0]  cnt0;
    // Instance 1: 8-bit signed, 8-bit index
    logic        ir1, ov1, of1;
    logic [7:0]  max1, min1;
    logic [7:0]  maxi1, mini1;
    logic [8:0]  cnt1;
    // Instance 2: 8-bit unsigned, 2-bit index
    logic        ir2, ov2, of2;
    logic [7:0]  max2, min2;
    logic [1:0]  maxi2, mini2;
    logic [2:0]  cnt2;

    min_max_tracker #(.INPUT_BIT_WIDTH(32), .INDEX_BIT_WIDTH(8), .SIGNED(1'b0)) u_dut0 (
        .Clk(Clk), .Reset(Reset), .Clear(Clear), .InputValid(InputValid),
        .InputReady(ir0), .InputData(InputData), .InputLast(InputLast),
        .OutputValid(ov0), .OutputReady(OutputReady), .Max(max0), .Min(min0),
        .MaxIndex(maxi0), .MinIndex(mini0), .Count(cnt0), .Overflow(of0)
    );

    min_max_tracker #(.INPUT_BIT_WIDTH(8), .INDEX_BIT_WIDTH(8), .SIGNED(1'b1)) u_dut1 (
        .Clk(Clk), .Reset(Reset), .Clear(Clear), .InputValid(InputValid),
        .InputReady(ir1), .InputData(InputData[7:0]), .InputLast(InputLast),
        .OutputValid(ov1), .OutputReady(OutputReady), .Max(max1), .Min(min1),
        .MaxIndex(maxi1), .MinIndex(mini1), .Count(cnt1), .Overflow(of1)
    );

    min_max_tracker #(.INPUT_BIT_WIDTH(8), .INDEX_BIT_WIDTH(2), .SIGNED(1'b0)) u_dut2 (
        .Clk(Clk), .Reset(Reset), .Clear(Clear), .InputValid(InputValid),
        .InputReady(ir2), .InputData(InputData[7:0]), .InputLast(InputLast),
        .OutputValid(ov2), .OutputReady(OutputReady), .Max(max2), .Min(min2),
        .MaxIndex(maxi2), .MinIndex(mini2), .Count(cnt2), .Overflow(of2)
    );

    int unsigned sel = 0;
    logic        rdy_sel;
    assign rdy_sel = (sel == 0) ? ir0 : (sel == 1) ? ir1 : ir2;

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic do_reset();
        @(negedge Clk);
        Reset = 1'b1;
        @(posedge Clk);
        #1 Reset = 1'b0;
    endtask

    // Presents one sample and holds it until the selected instance accepts it.
    task automatic send(input logic [31:0] d, input logic last);
        int unsigned n = 0;
        @(negedge Clk);
        InputData  = d;
        InputLast  = last;
        InputValid = 1'b1;
        while (!rdy_sel && n < 50) begin
            @(negedge Clk);
            n++;
        end
        if (n >= 50) check("send_timeout", 64'd0, 64'd1);
        @(posedge Clk);
        #1;
        InputValid = 1'b0;
        InputLast  = 1'b0;
    endtask

    task automatic pulse_out_ready();
        @(negedge Clk);
        OutputReady = 1'b1;
        @(posedge Clk);
        #1 OutputReady = 1'b0;
    endtask

    initial begin
        // Reset state and repeated-value frame
        sel = 0;
        do_reset();
        check("rst_max", max0, 0);
        check("rst_min", min0, 0);
        check("rst_cnt", cnt0, 0);
        check("rst_ov", ov0, 0);
        check("rst_ir", ir0, 1);
        check("rst_of", of0, 0);
        send(12, 1'b0);
        check("t1_ov_mid", ov0, 0);
        send(12, 1'b1);
        check("t1_ov", ov0, 1);
        check("t1_ir", ir0, 0);
        check("t1_max", max0, 12);
        check("t1_min", min0, 12);
        check("t1_maxi", maxi0, 0);
        check("t1_mini", mini0, 0);
        check("t1_cnt", cnt0, 2);
        pulse_out_ready();
        check("t1_ov_after", ov0, 0);
        check("t1_ir_after", ir0, 1);

        // Unsigned frame with ties on the minimum
        OutputReady = 1'b1;
        send(100, 1'b0);
        send(0, 1'b0);
        send(1024, 1'b0);
        send(1023, 1'b0);
        send(0, 1'b1);
        check("t2_ov", ov0, 1);
        check("t2_max", max0, 1024);
        check("t2_maxi", maxi0, 2);
        check("t2_min", min0, 0);
        check("t2_mini", mini0, 1);
        check("t2_cnt", cnt0, 5);
        @(posedge Clk);
        #1;
        check("t2_ov_next", ov0, 0);
        check("t2_ir_next", ir0, 1);

        // Signed vs unsigned compare of the same 8-bit frame
        OutputReady = 1'b0;
        sel = 1;
        do_reset();
        send(32'h05, 1'b0);
        send(32'h80, 1'b0);
        send(32'h7F, 1'b1);
        check("t3s_ov", ov1, 1);
        check("t3s_max", max1, 8'h7F);
        check("t3s_maxi", maxi1, 2);
        check("t3s_min", min1, 8'h80);
        check("t3s_mini", mini1, 1);
        check("t3u_max", max2, 8'h80);
        check("t3u_maxi", maxi2, 1);
        check("t3u_min", min2, 8'h05);
        check("t3u_mini", mini2, 0);

        // Backpressure on the result while a new sample waits
        sel = 0;
        do_reset();
        send(7, 1'b1);
        @(negedge Clk);
        InputData  = 99;
        InputValid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge Clk);
            #1;
            check("t4_ir_held", ir0, 0);
        end
        check("t4_max", max0, 7);
        check("t4_min", min0, 7);
        check("t4_cnt", cnt0, 1);
        check("t4_ov", ov0, 1);
        @(negedge Clk);
        OutputReady = 1'b1;
        @(posedge Clk);
        #1;
        check("t4_ov_acc", ov0, 0);
        @(posedge Clk);
        #1;
        InputValid  = 1'b0;
        OutputReady = 1'b0;
        check("t4_new_max", max0, 99);
        check("t4_new_cnt", cnt0, 1);

        // Forced termination at maximum frame length
        sel = 2;
        do_reset();
        send(1, 1'b0);
        send(2, 1'b0);
        send(3, 1'b0);
        send(4, 1'b0);
        check("t5_ov", ov2, 1);
        check("t5_cnt", cnt2, 4);
        check("t5_max", max2, 4);
        check("t5_maxi", maxi2, 3);
        check("t5_min", min2, 1);
        check("t5_of", of2, 1);
        pulse_out_ready();
        check("t5_ov_acc", ov2, 0);
        send(5, 1'b1);
        check("t5b_ov", ov2, 1);
        check("t5b_of", of2, 0);
        check("t5b_cnt", cnt2, 1);
        check("t5b_max", max2, 5);
        pulse_out_ready();

        // Clear mid-frame, then a single-sample frame
        sel = 0;
        do_reset();
        send(1, 1'b0);
        send(2, 1'b0);
        send(3, 1'b0);
        @(negedge Clk);
        Clear      = 1'b1;
        InputValid = 1'b1;
        InputData  = 50;
        @(posedge Clk);
        #1;
        Clear      = 1'b0;
        InputValid = 1'b0;
        check("t6_clr_ov", ov0, 0);
        check("t6_clr_ir", ir0, 1);
        check("t6_clr_cnt", cnt0, 3);
        send(9, 1'b1);
        check("t6_ov", ov0, 1);
        check("t6_max", max0, 9);
        check("t6_min", min0, 9);
        check("t6_cnt", cnt0, 1);
        check("t6_maxi", maxi0, 0);
        pulse_out_ready();

        // Reset on the same cycle as the last accept
        send(5, 1'b0);
        @(negedge Clk);
        InputData  = 6;
        InputLast  = 1'b1;
        InputValid = 1'b1;
        Reset      = 1'b1;
        @(posedge Clk);
        #1;
        Reset      = 1'b0;
        InputValid = 1'b0;
        InputLast  = 1'b0;
        @(posedge Clk);
        #1;
        check("t7_ov", ov0, 0);
        check("t7_max", max0, 0);
        check("t7_min", min0, 0);
        check("t7_cnt", cnt0, 0);
        check("t7_maxi", maxi0, 0);
        check("t7_mini", mini0, 0);
        check("t7_of", of0, 0);
        check("t7_ir", ir0, 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/min_max_tracker.md
Name: min_max_tracker

Overview:
Streaming successor to the two-input MinMax comparator. It accepts a frame of samples over a valid/ready handshake and tracks the running maximum and minimum of the frame, plus the index of each. At frame end it presents the result on a held output handshake. Width, index range and signed/unsigned compare are parameters. It sits between sample producers (ADC capture, counters) and statistics/consumer logic.

Parameters:
INPUT_BIT_WIDTH, 32, sample width in bits
INDEX_BIT_WIDTH, 8, width of sample index/count; max frame length 2^INDEX_BIT_WIDTH
SIGNED, 0, 0 = unsigned compare, 1 = two's-complement compare

Ports:
Clk  input  1  clock; all logic on rising edge
Reset  input  1  synchronous, active-high reset
Clear  input  1  synchronous abort of current frame/result
InputValid  input  1  sample present on InputData
InputReady  output  1  block can accept a sample
InputData  input  INPUT_BIT_WIDTH  sample
InputLast  input  1  marks final sample of frame
OutputValid  output  1  result available
OutputReady  input  1  consumer accepts result
Max  output  INPUT_BIT_WIDTH  running/final maximum
Min  output  INPUT_BIT_WIDTH  running/final minimum
MaxIndex  output  INDEX_BIT_WIDTH  index of first occurrence of Max
MinIndex  output  INDEX_BIT_WIDTH  index of first occurrence of Min
Count  output  INDEX_BIT_WIDTH+1  samples accepted in frame
Overflow  output  1  frame was force-terminated at max length

Behaviour:
- One clock (Clk); reset synchronous, active-high (Reset). Priority: Reset > Clear > handshake.
- Reset: state EMPTY; Max, Min, MaxIndex, MinIndex, Count = 0; Overflow = 0; OutputValid = 0; InputReady = 1.
- Accept = InputValid && InputReady. OutputAccept = OutputValid && OutputReady.
- InputReady = 1 in EMPTY and ACCUM; 0 in DONE. Combinational from state only, never from InputValid.
- States:
- EMPTY: on accept, Max = Min = InputData, MaxIndex = MinIndex = 0, Count = 1, Overflow = 0. Go to DONE if InputLast, else ACCUM.
- ACCUM: on accept, if InputData > Max (strict), Max = InputData and MaxIndex = Count. If InputData < Min (strict), Min = InputData and MinIndex = Count. Count += 1. Ties keep the earliest index.
- ACCUM exit: go to DONE if InputLast, or if the accepted sample's index = 2^INDEX_BIT_WIDTH-1. In the forced case without InputLast, set Overflow = 1 and treat the next sample as the start of a new frame.
- DONE: OutputValid = 1; Max, Min, MaxIndex, MinIndex, Count and Overflow held stable. On OutputAccept, go to EMPTY; OutputValid = 0 and InputReady = 1 from the next cycle. The result registers keep their values until the next frame's first accept.
- Latency: OutputValid rises on the cycle after the last sample is accepted. The minimum frame period is frame length + 1 cycle when OutputReady is held high.
- Compare: SIGNED=0 uses unsigned magnitude. SIGNED=1 uses two's complement, so 0x8000_0000 is less than 0 at width 32.
- Max, Min, MaxIndex and MinIndex are also visible as running values during ACCUM. They are contractually valid only while OutputValid = 1.
- Clear: go to EMPTY next cycle and drop OutputValid. A partial frame or pending result is discarded. Data on the Clear cycle is not accepted. Registers are not zeroed.
- Clear and Reset take effect regardless of InputValid or OutputReady.
- Reset mid-frame: identical to power-on reset. A pending result is lost.
- Single-sample frame (InputLast on the first accept): Max = Min = sample, both indices 0, Count = 1.
- InputData, InputLast and InputValid are ignored while InputReady = 0.

Test Plan:
- Reset then frame 12, 12 (Last): Max = 12, Min = 12, MaxIndex = 0, MinIndex = 0, Count = 2, OutputValid 1 cycle after Last.
- Unsigned frame 100, 0, 1024, 1023, 0 (Last), OutputReady = 1: Max = 1024 at index 2, Min = 0 at index 1 (first occurrence), Count = 5; next cycle OutputValid = 0, InputReady = 1.
- SIGNED=1, width 8, frame 0x05, 0x80, 0x7F (Last): Max = 0x7F at index 2, Min = 0x80 at index 1. The SIGNED=0 run of the same frame gives Max = 0x80 at index 1, Min = 0x05 at index 0.
- Backpressure: complete frame 7 (Last) with OutputReady = 0 for 5 cycles while InputValid = 1 with data 99. InputReady stays 0, the result stays Max = Min = 7 and 99 is not counted. Raise OutputReady: accepted, and 99 is then taken as the first sample of the new frame.
- INDEX_BIT_WIDTH=2, stream 1..5 with no Last: after 4 samples, DONE with Count = 4, Max = 4 at index 3, Overflow = 1; after the result is accepted, sample 5 starts a new frame with Overflow = 0.
- Clear after 3 samples of a frame, then frame 9 (Last): result is Max = Min = 9, Count = 1. Also repeat with Reset asserted on the same cycle as the Last accept: OutputValid stays 0 and all outputs are 0.
